fifo_drain_serializer: RTL and testbench
========================================

// Module: fifo_drain_serializer
// PURPOSE
// - Read-side controller for the shift-register FIFO built from register_stage cells.
// - Watches the head stage, pops one word per shift_out pulse, and serializes it into OUT_W-bit slices.
// - Downstream consumer uses a valid/ready handshake; sits between the FIFO head and narrow links.
// PARAMETERS
// - WIDTH   32  FIFO word width; must be an integer multiple of OUT_W.
// - OUT_W   8   output slice width; NUM_SLICES = WIDTH/OUT_W (>=1).
// PORTS
// - clk         in   1      single clock, all state on posedge
// - res_n       in   1      reset, asynchronous, active-low
// - head_data   in   WIDTH  data_out of FIFO head stage
// - head_filled in   1      filled flag of FIFO head stage
// - shift_out   out  1      pop pulse to all FIFO stages' shift_out
// - out_data    out  OUT_W  current slice
// - out_valid   out  1      slice valid
// - out_ready   in   1      consumer accepts slice when out_valid & out_ready
// - out_parity  out  1      only with FIFO_DRAIN_PARITY_EN (see CONFIGURATION)
// BEHAVIOUR
// - Reset (res_n low, async): state=IDLE, word_reg=0, slice_cnt=0, out_valid=0, out_data=0; shift_out=0.
// - States: IDLE (no word held), SEND (word_reg held, slices pending).
// - shift_out is combinational: (IDLE & head_filled) | (SEND & last & out_ready & head_filled); never set in reset.
// - Pop edge (shift_out=1): word_reg<=head_data, slice_cnt<=0, state<=SEND; head_data sampled same cycle.
// - IDLE: out_valid=0; on head_filled -> pop, out_valid=1 next cycle (1-cycle latency head->first slice).
// - SEND: out_valid=1; out_data=word_reg[slice_cnt*OUT_W +: OUT_W], LSB slice first.
// - Transfer (valid&ready), not last: slice_cnt++; last = (slice_cnt==NUM_SLICES-1).
// - Transfer on last: head_filled -> pop (back-to-back, no bubble); else state<=IDLE, out_valid<=0.
// - Stall (valid&!ready): out_data, slice_cnt, word_reg held stable; no pop.
// - At most one pop per NUM_SLICES transfers; never pops while a slice is pending.
// - NUM_SLICES==1: every transfer is last; throughput one word/cycle with ready held high.
// - Concurrent FIFO write during pop is the FIFO's concern; drain only relies on head_filled/head_data.
// - Reset mid-SEND: held word discarded (already popped); no partial slice after reset.
// - slice_cnt width = max(1,$clog2(NUM_SLICES)); never exceeds NUM_SLICES-1.
// CONFIGURATION
// - FIFO_DRAIN_PARITY_EN defined: port out_parity = ^out_data (even parity, combinational, valid with out_valid).
// - Undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
// - Package fifo_drain_pkg: state typedef (IDLE/SEND), function num_slices(WIDTH,OUT_W), cnt width helper.
// - One sub-module: fifo_drain_slice_counter (clear/inc/last, parameter NUM_SLICES).
// - Elaboration check: fatal if WIDTH % OUT_W != 0 or OUT_W > WIDTH.
// TESTING
// - Reset: hold res_n=0 with head_filled=1 -> shift_out=0, out_valid=0, out_data=0.
// - Single word: head_data=32'hA1B2C3D4, head_filled 1 cycle, ready=1 -> one shift_out, slices D4,C3,B2,A1, then IDLE.
// - Back-to-back: 2 words queued, ready=1 -> 8 consecutive valid cycles, 2nd pop on 4th transfer cycle, no bubble.
// - Backpressure: ready low 3 cycles mid-word -> out_data stable, no shift_out, order preserved.
// - Reset mid-SEND after 2 slices -> outputs to reset values; next word starts at slice 0.
// - FIFO_DRAIN_PARITY_EN: slice 8'h07 -> out_parity=1; 8'h03 -> 0; WIDTH=OUT_W=8 -> one pop per transfer.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// Shared types and sizing helpers for the FIFO drain serializer.
package fifo_drain_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

  // Slices per FIFO word; guarded so a bad configuration still elaborates far enough to report.
  function automatic int unsigned num_slices(input int unsigned width, input int unsigned out_w);
    if (out_w == 0 || out_w > width) return 1;
    return width / out_w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input int unsigned out_w);
    return (out_w != 0) && (out_w <= width) && ((width % out_w) == 0);
  endfunction

endpackage

// File: rtl/fifo_drain_slice_counter.sv
// Slice index counter for the drain serializer: synchronous clear, increment, last-slice flag.
module fifo_drain_slice_counter
  import fifo_drain_pkg::*;
#(
  parameter int unsigned NUM_SLICES = 4,
  localparam int unsigned CNT_W = cnt_width(NUM_SLICES)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last_c
);

  assign last_c = (cnt == CNT_W'(NUM_SLICES - 1));

  // Clear wins over increment so a pop always restarts at the LSB slice.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_drain_serializer.sv
// Pops words from the shift-register FIFO head and emits them as OUT_W-bit slices, LSB first.
// Optional even-parity output is enabled by defining FIFO_DRAIN_PARITY_EN.
module fifo_drain_serializer
  import fifo_drain_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [WIDTH-1:0] head_data,
  input  logic             head_filled,
  output logic             shift_out,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
`ifdef FIFO_DRAIN_PARITY_EN
  output logic             out_parity,
`endif
  input  logic             out_ready
);

  localparam int unsigned NUM_SLICES = num_slices(WIDTH, OUT_W);
  localparam int unsigned CNT_W      = cnt_width(NUM_SLICES);

  if (!cfg_ok(WIDTH, OUT_W)) begin : g_cfg_check
    $fatal(1, "fifo_drain_serializer: WIDTH must be a non-zero multiple of OUT_W");
  end

  drain_state_t     state;
  drain_state_t     state_nxt;
  logic [WIDTH-1:0] word_reg;
  logic [CNT_W-1:0] slice_cnt;
  logic             slice_last_c;
  logic             slice_inc_c;
  logic             xfer_c;
  logic             pop_c;

  fifo_drain_slice_counter #(
    .NUM_SLICES(NUM_SLICES)
  ) u_slice_cnt (
    .clk    (clk),
    .res_n  (res_n),
    .clear  (pop_c),
    .inc    (slice_inc_c),
    .cnt    (slice_cnt),
    .last_c (slice_last_c)
  );

  // Next state and pop decision; a pop is only legal when no slice is left pending.
  always_comb begin
    state_nxt   = state;
    pop_c       = 1'b0;
    slice_inc_c = 1'b0;
    xfer_c      = out_valid & out_ready;
    case (state)
      IDLE: begin
        if (head_filled) pop_c = 1'b1;
      end
      SEND: begin
        if (xfer_c) begin
          if (!slice_last_c) begin
            slice_inc_c = 1'b1;
          end else if (head_filled) begin
            pop_c = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // The FIFO must never shift while this block is held in reset.
    if (!res_n) pop_c = 1'b0;
    if (pop_c) state_nxt = SEND;
  end

  assign shift_out = pop_c;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= IDLE;
      word_reg  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == SEND);
      if (pop_c) word_reg <= head_data;
    end
  end

  // Slice select from held word; constant part-selects keep every index in range.
  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < NUM_SLICES; i++) begin
      if (slice_cnt == CNT_W'(i)) out_data = word_reg[i*OUT_W +: OUT_W];
    end
  end

`ifdef FIFO_DRAIN_PARITY_EN
  assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Directed, table-driven bench for fifo_drain_serializer (32/8 instance plus an 8/8 instance).
module tb_fifo_drain_serializer;

  logic        clk = 1'b0;
  logic        res_n;
  logic [31:0] head_data;
  logic        head_filled;
  logic        shift_out;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  logic [7:0]  head_data8;
  logic        head_filled8;
  logic        shift_out8;
  logic [7:0]  out_data8;
  logic        out_valid8;
  logic        out_ready8;
`ifdef FIFO_DRAIN_PARITY_EN
  logic        out_parity;
  logic        out_parity8;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fifo_drain_serializer #(.WIDTH(32), .OUT_W(8)) dut (
    .clk         (clk),
    .res_n       (res_n),
    .head_data   (head_data),
    .head_filled (head_filled),
    .shift_out   (shift_out),
    .out_data    (out_data),
    .out_valid   (out_valid),
`ifdef FIFO_DRAIN_PARITY_EN
    .out_parity  (out_parity),
`endif
    .out_ready   (out_ready)
  );

  fifo_drain_serializer #(.WIDTH(8), .OUT_W(8)) dut8 (
    .clk         (clk),
    .res_n       (res_n),
    .head_data   (head_data8),
    .head_filled (head_filled8),
    .shift_out   (shift_out8),
    .out_data    (out_data8),
    .out_valid   (out_valid8),
`ifdef FIFO_DRAIN_PARITY_EN
    .out_parity  (out_parity8),
`endif
    .out_ready   (out_ready8)
  );

  typedef struct {
    logic        rst_n;
    logic        hf;
    logic [31:0] hd;
    logic        rdy;
    logic        e_shift;
    logic        e_valid;
    logic        chk_data;
    logic [7:0]  e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic hf, input logic [31:0] hd, input logic rdy,
                              input logic es, input logic ev, input logic cd, input logic [7:0] ed);
    vec_t v;
    v.rst_n = r;  v.hf = hf;  v.hd = hd;  v.rdy = rdy;
    v.e_shift = es;  v.e_valid = ev;  v.chk_data = cd;  v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step8(input string tag, input logic hf, input logic [7:0] hd, input logic rdy,
                       input logic es, input logic ev, input logic [7:0] ed);
    @(negedge clk);
    head_filled8 = hf;  head_data8 = hd;  out_ready8 = rdy;
    #2;
    chk({tag, "_shift"}, 32'(shift_out8), 32'(es));
    chk({tag, "_valid"}, 32'(out_valid8), 32'(ev));
    if (ev) begin
      chk({tag, "_data"}, 32'(out_data8), 32'(ed));
`ifdef FIFO_DRAIN_PARITY_EN
      chk({tag, "_par"}, 32'(out_parity8), 32'(^ed));
`endif
    end
  endtask

  initial begin
    // columns: res_n, head_filled, head_data, out_ready | shift_out, out_valid, check data, out_data
    // reset with a word present: no pop, outputs at reset values
    vecs.push_back(mk(0, 1, 32'hA1B2C3D4, 1, 0, 0, 1, 8'h00));
    vecs.push_back(mk(0, 1, 32'hA1B2C3D4, 1, 0, 0, 1, 8'h00));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 1, 8'h00));
    // single word
    vecs.push_back(mk(1, 1, 32'hA1B2C3D4, 1, 1, 0, 1, 8'h00));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'hD4));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'hC3));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'hB2));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'hA1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 0, 8'h00));
    // back-to-back: second pop on the last transfer of the first word
    vecs.push_back(mk(1, 1, 32'h11223344, 1, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 1, 32'h55667788, 1, 0, 1, 1, 8'h44));
    vecs.push_back(mk(1, 1, 32'h55667788, 1, 0, 1, 1, 8'h33));
    vecs.push_back(mk(1, 1, 32'h55667788, 1, 0, 1, 1, 8'h22));
    vecs.push_back(mk(1, 1, 32'h55667788, 1, 1, 1, 1, 8'h11));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'h88));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'h77));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'h66));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'h55));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 0, 8'h00));
    // backpressure mid-word, then stall on the last slice with a word waiting
    vecs.push_back(mk(1, 1, 32'hDEADBEEF, 1, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'hEF));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'hBE));
    vecs.push_back(mk(1, 1, 32'hCAFEF00D, 0, 0, 1, 1, 8'hAD));
    vecs.push_back(mk(1, 1, 32'hCAFEF00D, 0, 0, 1, 1, 8'hAD));
    vecs.push_back(mk(1, 1, 32'hCAFEF00D, 0, 0, 1, 1, 8'hAD));
    vecs.push_back(mk(1, 1, 32'hCAFEF00D, 1, 0, 1, 1, 8'hAD));
    vecs.push_back(mk(1, 1, 32'hCAFEF00D, 0, 0, 1, 1, 8'hDE));
    vecs.push_back(mk(1, 1, 32'hCAFEF00D, 1, 1, 1, 1, 8'hDE));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'h0D));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'hF0));
    // reset mid-word after two slices; next word restarts at slice 0
    vecs.push_back(mk(0, 1, 32'h12345678, 1, 0, 0, 1, 8'h00));
    vecs.push_back(mk(0, 1, 32'h12345678, 1, 0, 0, 1, 8'h00));
    vecs.push_back(mk(1, 1, 32'h12345678, 1, 1, 0, 1, 8'h00));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'h78));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'h56));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'h34));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 1, 1, 8'h12));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 0, 8'h00));

    res_n = 1'b0;  head_filled = 1'b0;  head_data = '0;  out_ready = 1'b0;
    head_filled8 = 1'b0;  head_data8 = '0;  out_ready8 = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      res_n = vecs[i].rst_n;  head_filled = vecs[i].hf;
      head_data = vecs[i].hd;  out_ready = vecs[i].rdy;
      #2;
      chk($sformatf("row%0d_shift", i), 32'(shift_out), 32'(vecs[i].e_shift));
      chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      if (vecs[i].chk_data) chk($sformatf("row%0d_data", i), 32'(out_data), 32'(vecs[i].e_data));
`ifdef FIFO_DRAIN_PARITY_EN
      if (vecs[i].e_valid) chk($sformatf("row%0d_par", i), 32'(out_parity), 32'(^vecs[i].e_data));
`endif
    end

    // single-slice configuration: every transfer is last, one pop per transfer
    step8("w8_c1", 1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 8'h00);
    step8("w8_c2", 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h07);
    step8("w8_c3", 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h07);
    step8("w8_c4", 1'b1, 8'hF1, 1'b1, 1'b1, 1'b1, 8'h03);
    step8("w8_c5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hF1);
    step8("w8_c6", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
